// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: state encoding, error bit indices and default sizing shared by the FFT frame sequencer.
package fft_ctrl_pkg;
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CFG      = 3'd1,
      S_LOAD     = 3'd2,
      S_WAIT_OUT = 3'd3,
      S_DONE     = 3'd4
   } state_e;
   localparam int ERR_UNEXP     = 0;
   localparam int ERR_MISSING   = 1;
   localparam int ERR_TIMEOUT   = 2;
   localparam int ERR_LEN       = 3;
   localparam int NFFT_LOG2_DEF = 9;
   localparam int TIMEOUT_DEF   = 4096;
endpackage

// File: rtl/fft_frame_counter.sv
// fft_frame_counter: up-counter with priority clear, enable and a terminal-count flag.
module fft_frame_counter #(
   parameter int          W  = 9,
   parameter int unsigned TC = 511
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   assign tc_o = cnt_q == W'(TC);
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: per-frame sequencer for a streaming FFT core -- one config beat, NFFT gated
// input samples with generated tlast, then supervision of the output frame with a timeout.
module fft_frame_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int CFG_W     = 8,
   parameter int NFFT_LOG2 = NFFT_LOG2_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CFG_W-1:0]  cfg_word,
   input  logic [DATA_W-1:0] src_tdata,
   input  logic              src_tvalid,
   output logic              src_tready,
   output logic [CFG_W-1:0]  s_axis_config_tdata,
   output logic              s_axis_config_tvalid,
   input  logic              s_axis_config_tready,
   output logic [DATA_W-1:0] s_axis_data_tdata,
   output logic              s_axis_data_tvalid,
   input  logic              s_axis_data_tready,
   output logic              s_axis_data_tlast,
   input  logic              m_axis_data_tvalid,
   input  logic              m_axis_data_tlast,
   input  logic              event_tlast_unexpected,
   input  logic              event_tlast_missing,
   output logic              busy,
   output logic              done,
   output logic [3:0]        err,
   output logic [15:0]       frame_cnt
);
   localparam int NFFT = 1 << NFFT_LOG2;
   localparam int TW   = $clog2(TIMEOUT);
   state_e             state_q, state_d;
   logic [CFG_W-1:0]   cfg_q, cfg_d;
   logic               cfg_vld_q, cfg_vld_d;
   logic [3:0]         err_q, err_d;
   logic [15:0]        frame_q, frame_d;
   logic               in_load, in_wait, data_hs, out_beat, in_last, out_last, tmr_exp;
   assign in_load  = state_q == S_LOAD;
   assign in_wait  = state_q == S_WAIT_OUT;
   assign data_hs  = in_load & src_tvalid & s_axis_data_tready;
   assign out_beat = in_wait & m_axis_data_tvalid;
   fft_frame_counter #(.W(NFFT_LOG2), .TC(NFFT - 1)) u_in_cnt (
      .clk, .rst_n, .clr_i(!in_load), .en_i(data_hs), .tc_o(in_last));
   fft_frame_counter #(.W(NFFT_LOG2), .TC(NFFT - 1)) u_out_cnt (
      .clk, .rst_n, .clr_i(!in_wait), .en_i(out_beat), .tc_o(out_last));
   fft_frame_counter #(.W(TW), .TC(TIMEOUT - 1)) u_timer (
      .clk, .rst_n, .clr_i(!in_wait), .en_i(1'b1), .tc_o(tmr_exp));
   // An accepted start clears err after the event OR, so a coincident event is dropped.
   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      cfg_vld_d = cfg_vld_q;
      frame_d   = frame_q;
      err_d     = err_q;
      err_d[ERR_UNEXP]   = err_q[ERR_UNEXP] | event_tlast_unexpected;
      err_d[ERR_MISSING] = err_q[ERR_MISSING] | event_tlast_missing;
      case (state_q)
         S_IDLE: if (start) begin
            state_d   = S_CFG;
            cfg_d     = cfg_word;
            cfg_vld_d = 1'b1;
            err_d     = '0;
         end
         S_CFG: if (s_axis_config_tready) begin
            state_d   = S_LOAD;
            cfg_vld_d = 1'b0;
         end
         S_LOAD: if (data_hs && in_last) state_d = S_WAIT_OUT;
         S_WAIT_OUT:
            if (out_beat && m_axis_data_tlast) begin
               state_d = S_DONE;
               err_d[ERR_LEN] = err_q[ERR_LEN] | !out_last;
            end else if (tmr_exp) begin
               state_d = S_IDLE;
               err_d[ERR_TIMEOUT] = 1'b1;
            end
         S_DONE: begin
            state_d = S_IDLE;
            frame_d = frame_q + 16'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cfg_q     <= '0;
         cfg_vld_q <= 1'b0;
         err_q     <= '0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         cfg_vld_q <= cfg_vld_d;
         err_q     <= err_d;
         frame_q   <= frame_d;
      end
   assign s_axis_config_tdata  = cfg_q;
   assign s_axis_config_tvalid = cfg_vld_q;
   assign s_axis_data_tdata    = src_tdata;
   assign s_axis_data_tvalid   = in_load & src_tvalid;
   assign src_tready           = in_load & s_axis_data_tready;
   assign s_axis_data_tlast    = in_load & in_last;
   assign busy                 = state_q != S_IDLE;
   assign done                 = state_q == S_DONE;
   assign err                  = err_q;
   assign frame_cnt            = frame_q;
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Sequencer that drives one streaming FFT core per frame: issues the configuration word, gates NFFT source samples into the core with a generated tlast, then waits for the full output frame.
- Sits between the sample source and the FFT core's s_axis_config / s_axis_data ports, and monitors m_axis_data and the core's event outputs.
- Replaces free-running tvalid/tlast glue with a start/done/error handshake for the system controller.

Parameters:
- DATA_W, 32, sample width (re/im packed).
- CFG_W, 8, FFT config word width.
- NFFT_LOG2, 9, log2 of frame length (NFFT = 512).
- TIMEOUT, 4096, maximum cycles in WAIT_OUT before abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins one frame when idle.
- cfg_word  in  CFG_W  config word (bit0 = 1 forward), latched on accepted start.
- src_tdata  in  DATA_W  source sample.
- src_tvalid  in  1  source sample valid.
- src_tready  out  1  source may advance.
- s_axis_config_tdata  out  CFG_W  to FFT.
- s_axis_config_tvalid  out  1  to FFT.
- s_axis_config_tready  in  1  from FFT.
- s_axis_data_tdata  out  DATA_W  to FFT.
- s_axis_data_tvalid  out  1  to FFT.
- s_axis_data_tready  in  1  from FFT.
- s_axis_data_tlast  out  1  to FFT.
- m_axis_data_tvalid  in  1  FFT output valid (core m_tready tied 1).
- m_axis_data_tlast  in  1  FFT output last.
- event_tlast_unexpected  in  1  FFT event pulse.
- event_tlast_missing  in  1  FFT event pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.
- err  out  4  sticky: [0] tlast_unexpected, [1] tlast_missing, [2] timeout, [3] output length mismatch.
- frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all counters, err, frame_cnt, done, config tvalid and latched config = 0.
- States: IDLE, CFG, LOAD, WAIT_OUT, DONE.
- IDLE:
  - start = 1 -> latch cfg_word, clear err, go to CFG next cycle.
  - start while busy is ignored.
- CFG:
  - s_axis_config_tvalid = 1 and s_axis_config_tdata = latched word, both registered.
  - On tvalid && tready -> LOAD. tvalid drops the same edge.
  - tdata is held stable while tready = 0.
- LOAD:
  - Combinational pass-through: s_axis_data_tvalid = src_tvalid, src_tready = s_axis_data_tready, s_axis_data_tdata = src_tdata.
  - In all other states: s_axis_data_tvalid = 0 and src_tready = 0.
  - in_cnt (NFFT_LOG2 bits) increments on each data handshake.
  - s_axis_data_tlast = 1 exactly when in_cnt == NFFT-1 (combinational, LOAD only).
  - Handshake with in_cnt == NFFT-1 -> in_cnt = 0, go to WAIT_OUT.
- WAIT_OUT:
  - out_cnt increments on each m_axis_data_tvalid.
  - m_axis_data_tvalid && m_axis_data_tlast -> go to DONE; set err[3] if out_cnt != NFFT-1 at that beat.
  - Timer counts cycles in this state. If the timer reaches TIMEOUT-1 with no tlast: set err[2], go to IDLE, no done pulse, frame_cnt unchanged.
  - Output beats arriving in any other state are ignored.
- DONE:
  - done = 1 for one cycle, frame_cnt += 1, go to IDLE.
  - Latency: start to first possible config handshake = 1 cycle; DONE follows the output tlast beat by 1 cycle.
- Error events:
  - event_tlast_unexpected / event_tlast_missing set err[0] / err[1] in any state.
  - Events do not alter the FSM.
  - err clears only on an accepted start or reset.
- Simultaneous start and event in IDLE: the clear wins for that cycle; the event is lost. This is documented behaviour.

Decomposition:
- Shared package fft_ctrl_pkg holds:
  - state encoding enum (IDLE=0 .. DONE=4);
  - err bit index constants;
  - default NFFT_LOG2 / TIMEOUT.
- One natural sub-module: fft_frame_counter, a parameterised up-counter with enable, clear and terminal-count flag. Instantiate it for in_cnt, out_cnt and the timeout timer.

Test Plan:
- Nominal frame: cfg_word = 0x01, source always valid, FFT ready -> one config beat with tdata 0x01; 512 data beats; tlast only on beat 511; FFT returns 512 beats with tlast on 511 -> done pulse, frame_cnt = 1, err = 0.
- Backpressure: s_axis_data_tready toggles 1/0 and src_tvalid random 50% -> exactly 512 handshakes; tlast only on handshake 511; tdata order preserved; tlast held while stalled at beat 511.
- Config stall: s_axis_config_tready low for 10 cycles after entering CFG -> tvalid and tdata 0x01 held stable; no data beat accepted before the config handshake.
- Timeout: no output beats after load, TIMEOUT = 64 -> IDLE 64 cycles after entering WAIT_OUT; err = 4'b0100; no done pulse; frame_cnt unchanged; next start clears err.
- Short output frame: output tlast on beat 255 -> done pulses; err[3] = 1; inject event_tlast_missing during LOAD -> err[1] = 1, FSM unaffected.
- Reset mid-LOAD at beat 200, plus start pulsed while busy -> on reset all outputs 0 and state IDLE; the following frame again counts from 0 (tlast on beat 511); the start pulsed while busy produces no extra frame.
